// File: rtl/proc_gen.sv
// proc_gen: multi-cycle processor core with eight general registers R0..R7,
// operand register A and result register G on a shared W-bit bus.
// Instructions arrive on DIN under a Run/Done handshake. Fields sit in the
// top nine bits of the word: opcode [W-1:W-3], X [W-4:W-6], Y [W-7:W-9].
// Optional feature macro: PROC_GEN_LOGIC_EN enables the and/or opcodes as
// four-cycle ALU ops. Without it those opcodes behave as nop.
module proc_gen #(
  parameter int unsigned W = 9
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         Run,
  input  logic [W-1:0] DIN,
  input  logic [2:0]   DbgSel,
  output logic         Done,
  output logic [W-1:0] BusWires,
  output logic [W-1:0] DbgData
);

  localparam logic [2:0] OpMv   = 3'b000;
  localparam logic [2:0] OpMvi  = 3'b001;
  localparam logic [2:0] OpAdd  = 3'b010;
  localparam logic [2:0] OpSub  = 3'b011;
  localparam logic [2:0] OpMvnz = 3'b100;
`ifdef PROC_GEN_LOGIC_EN
  localparam logic [2:0] OpAnd  = 3'b101;
  localparam logic [2:0] OpOr   = 3'b110;
`endif

  typedef enum logic [1:0] {
    StT0 = 2'd0,
    StT1 = 2'd1,
    StT2 = 2'd2,
    StT3 = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [8:0]     ir_q, ir_d;
  logic [W-1:0]   regs_q [8];
  logic [W-1:0]   regs_d [8];
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   g_q, g_d;

  // Control strobes from the FSM
  logic           ir_in;
  logic           din_out;
  logic           g_out;
  logic [7:0]     r_out;
  logic [7:0]     r_in;
  logic           a_in;
  logic           g_in;

  logic [2:0]     op;
  logic [2:0]     rx;
  logic [2:0]     ry;
  logic           is_alu;
  logic [W-1:0]   alu_res;

  assign op = ir_q[8:6];
  assign rx = ir_q[5:3];
  assign ry = ir_q[2:0];

  // Opcodes that take the four-cycle A/G path
  always_comb begin
    is_alu = (op == OpAdd) || (op == OpSub);
`ifdef PROC_GEN_LOGIC_EN
    is_alu = is_alu || (op == OpAnd) || (op == OpOr);
`endif
  end

  // FSM next-state and control strobes
  always_comb begin
    state_d = state_q;
    ir_in   = 1'b0;
    din_out = 1'b0;
    g_out   = 1'b0;
    r_out   = '0;
    r_in    = '0;
    a_in    = 1'b0;
    g_in    = 1'b0;
    Done    = 1'b0;
    unique case (state_q)
      StT0: begin
        if (Run) begin
          ir_in   = 1'b1;
          state_d = StT1;
        end
      end
      StT1: begin
        if (is_alu) begin
          r_out[rx] = 1'b1;
          a_in      = 1'b1;
          state_d   = StT2;
        end else begin
          // Short ops finish here; nop and disabled logic ops only raise Done
          case (op)
            OpMv: begin
              r_out[ry] = 1'b1;
              r_in[rx]  = 1'b1;
            end
            OpMvi: begin
              din_out  = 1'b1;
              r_in[rx] = 1'b1;
            end
            OpMvnz: begin
              r_out[ry] = 1'b1;
              r_in[rx]  = (g_q != '0);
            end
            default: ;
          endcase
          Done    = 1'b1;
          state_d = StT0;
        end
      end
      StT2: begin
        r_out[ry] = 1'b1;
        g_in      = 1'b1;
        state_d   = StT3;
      end
      StT3: begin
        g_out    = 1'b1;
        r_in[rx] = 1'b1;
        Done     = 1'b1;
        state_d  = StT0;
      end
      default: state_d = StT0;
    endcase
  end

  // Shared bus: sources are mutually exclusive, idle bus reads as zero
  always_comb begin
    BusWires = '0;
    if (din_out) begin
      BusWires = DIN;
    end else if (g_out) begin
      BusWires = g_q;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (r_out[i]) BusWires = regs_q[i];
      end
    end
  end

  // ALU: A is the left operand, the bus carries Ry
  always_comb begin
    alu_res = a_q + BusWires;
    case (op)
      OpSub:   alu_res = a_q - BusWires;
`ifdef PROC_GEN_LOGIC_EN
      OpAnd:   alu_res = a_q & BusWires;
      OpOr:    alu_res = a_q | BusWires;
`endif
      default: alu_res = a_q + BusWires;
    endcase
  end

  // Register file, IR, A and G next-state from the load strobes
  always_comb begin
    ir_d = ir_in ? DIN[W-1 -: 9] : ir_q;
    a_d  = a_in ? BusWires : a_q;
    g_d  = g_in ? alu_res : g_q;
    for (int i = 0; i < 8; i++) begin
      regs_d[i] = r_in[i] ? BusWires : regs_q[i];
    end
  end

  // State and datapath registers; reset aborts any instruction in flight
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= StT0;
      ir_q    <= '0;
      a_q     <= '0;
      g_q     <= '0;
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      g_q     <= g_d;
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign DbgData = regs_q[DbgSel];

endmodule
